lif_array: RTL and testbench

Time-multiplexed array of current-based leaky integrate-and-fire neurons. It is the parametrised successor to the single-neuron LIF top. One shared update engine sweeps `N_CH` membrane registers, one channel per clock. Per-channel input currents are snapshotted at the start of each sweep, and the spike vector is published once per sweep. The block sits between the input-pin/current-encoder logic and the spike/state output muxing of the chip top.

---
 rtl/lif_array.sv | 162 ++++++++++++++++
 tb/tb_lif_array.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_array.sv
// rtl/lif_array.sv - time-multiplexed leaky integrate-and-fire neuron array (optional LIF_REFRACTORY_EN)
module lif_array #(
    parameter int N_CH          = 4,
    parameter int WIDTH         = 8,
    parameter int THRESHOLD     = 200,
    parameter int LEAK_SHIFT    = 2,
    parameter int REFRAC_SWEEPS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_CH*WIDTH-1:0]      current_in,
    input  logic [$clog2(N_CH)-1:0]    state_sel,
    output logic [WIDTH-1:0]           state_out,
    output logic [N_CH-1:0]            spike_out,
    output logic                       sweep_done,
    output logic                       busy
);

    localparam int CH_W = $clog2(N_CH);
    localparam logic [WIDTH-1:0] THR     = WIDTH'(THRESHOLD);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] v_mem [N_CH];
    logic [WIDTH-1:0] snap  [N_CH];
    logic [N_CH-1:0]  pending;

    // Shared update engine signals for the channel currently addressed by ch
    logic [WIDTH-1:0] cur_v;
    logic [WIDTH-1:0] cur_i;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sat;
    logic             over_thr;
    logic             in_refrac;
    logic             fire;
    logic [N_CH-1:0]  spike_bit;
    logic             last_ch;

`ifdef LIF_REFRACTORY_EN
    localparam logic [3:0] REFRAC = 4'(REFRAC_SWEEPS);
    logic [3:0] refr [N_CH];
`else
    localparam int unused_refrac_sweeps = REFRAC_SWEEPS;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: one sweep per accepted request, then a single DONE cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en) state_nxt = S_SWEEP;
            S_SWEEP: if (last_ch) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy       = (state != S_IDLE);
        sweep_done = (state == S_DONE);
    end

    // Leak, integrate, saturate and threshold the addressed channel
    always_comb begin
        last_ch  = (ch == LAST_CH);
        cur_v    = v_mem[ch];
        cur_i    = snap[ch];
        // V - (V >> shift) never underflows, so only the top carry needs handling
        sum      = {1'b0, cur_v} - {1'b0, (cur_v >> LEAK_SHIFT)} + {1'b0, cur_i};
        sat      = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        over_thr = (sat >= THR);
`ifdef LIF_REFRACTORY_EN
        in_refrac = (refr[ch] != 4'd0);
`else
        in_refrac = 1'b0;
`endif
        fire      = over_thr && !in_refrac;
        spike_bit = '0;
        spike_bit[ch] = fire;
    end

    // Channel state, snapshot and spike vector updates
    always_ff @(posedge clk) begin
        if (rst) begin
            ch        <= '0;
            pending   <= '0;
            spike_out <= '0;
            for (int k = 0; k < N_CH; k++) begin
                v_mem[k] <= '0;
                snap[k]  <= '0;
`ifdef LIF_REFRACTORY_EN
                refr[k]  <= 4'd0;
`endif
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        ch      <= '0;
                        pending <= '0;
                        for (int k = 0; k < N_CH; k++) begin
                            snap[k] <= current_in[k*WIDTH +: WIDTH];
                        end
                    end
                end
                S_SWEEP: begin
`ifdef LIF_REFRACTORY_EN
                    if (in_refrac) begin
                        v_mem[ch] <= '0;
                        refr[ch]  <= refr[ch] - 4'd1;
                    end else if (over_thr) begin
                        v_mem[ch] <= '0;
                        refr[ch]  <= REFRAC;
                    end else begin
                        v_mem[ch] <= sat;
                    end
`else
                    v_mem[ch] <= over_thr ? '0 : sat;
`endif
                    pending <= pending | spike_bit;
                    if (last_ch) begin
                        ch        <= '0;
                        // Publish on the last update edge so the vector is valid during DONE
                        spike_out <= pending | spike_bit;
                    end else begin
                        ch <= ch + CH_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Combinational membrane readback; out-of-range selects read as zero
    always_comb begin
        state_out = '0;
        if (int'(state_sel) < N_CH) begin
            state_out = v_mem[state_sel];
        end
    end

endmodule

// File: tb/tb_lif_array.sv
// tb/tb_lif_array.sv - self-checking bench for lif_array
module tb_lif_array;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] current_in;
    logic [1:0]  state_sel;
    logic [7:0]  state_out;
    logic [3:0]  spike_out;
    logic        sweep_done;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef LIF_REFRACTORY_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] cur;
        logic [3:0]  spk;
        logic [31:0] v;
    } vec_t;

    vec_t vecs [18];

    lif_array #(
        .N_CH(4), .WIDTH(8), .THRESHOLD(200), .LEAK_SHIFT(2), .REFRAC_SWEEPS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .current_in(current_in),
        .state_sel(state_sel),
        .state_out(state_out),
        .spike_out(spike_out),
        .sweep_done(sweep_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic read_v(input int k, output logic [7:0] v);
        state_sel = 2'(k);
        #1;
        v = state_out;
    endtask

    task automatic check_all_v(input string tag, input logic [31:0] exp);
        logic [7:0] v;
        for (int k = 0; k < 4; k++) begin
            read_v(k, v);
            check($sformatf("%s_v%0d", tag, k), {24'd0, v}, {24'd0, exp[k*8 +: 8]});
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sweep_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wait_done", {31'd0, sweep_done}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Single-cycle en pulse, returns in the DONE cycle
    task automatic run_sweep(input logic [31:0] cur);
        wait_idle();
        current_in = cur;
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_done();
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (sweep_done === 1'b1) cnt++;
        end
    endtask

    initial begin
        int          vt [6];
        int          cnt;
        int          last;
        int          ndone;
        int          nlow;
        logic [7:0]  v;

        vt = '{60, 105, 139, 165, 184, 198};

        // Integration on ch0, refractory on ch1, saturation on ch2
        for (int i = 0; i < 6; i++) begin
            vecs[i]      = '{cur: 32'h0000003C, spk: 4'b0000, v: 32'(vt[i])};
            vecs[11 + i] = '{cur: 32'h003C0000, spk: 4'b0000, v: 32'(vt[i]) << 16};
        end
        vecs[6]  = '{cur: 32'h0000003C, spk: 4'b0001, v: 32'h0};
        vecs[7]  = '{cur: 32'h0000FF00, spk: 4'b0010, v: 32'h0};
        vecs[8]  = '{cur: 32'h0000FF00, spk: REF_EN ? 4'b0000 : 4'b0010, v: 32'h0};
        vecs[9]  = '{cur: 32'h0000FF00, spk: REF_EN ? 4'b0000 : 4'b0010, v: 32'h0};
        vecs[10] = '{cur: 32'h0000FF00, spk: 4'b0010, v: 32'h0};
        vecs[17] = '{cur: 32'h00FF0000, spk: 4'b0100, v: 32'h0};

        // Reset with random inputs
        rst        = 1'b1;
        en         = 1'($urandom_range(0, 1));
        current_in = $urandom();
        state_sel  = 2'($urandom_range(0, 3));
        tick();
        en         = 1'($urandom_range(0, 1));
        current_in = $urandom();
        tick();
        check("rst_spike_out", {28'd0, spike_out}, 32'd0);
        check("rst_sweep_done", {31'd0, sweep_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check_all_v("rst", 32'h0);
        rst        = 1'b0;
        en         = 1'b0;
        current_in = 32'h0;
        tick();

        // Table-driven sweeps
        for (int i = 0; i < 18; i++) begin
            run_sweep(vecs[i].cur);
            check($sformatf("vec%0d_spike", i), {28'd0, spike_out}, {28'd0, vecs[i].spk});
            check_all_v($sformatf("vec%0d", i), vecs[i].v);
        end
        wait_idle();
        check("spike_hold", {28'd0, spike_out}, 32'h4);

        // Cycle-accurate timing and single-pulse behaviour
        do_reset();
        current_in = 32'h0000003C;
        check("t_busy_pre", {31'd0, busy}, 32'd0);
        en = 1'b1;
        tick();
        en = 1'b0;
        check("t_busy_e0", {31'd0, busy}, 32'd1);
        read_v(0, v);
        check("t_v0_e0", {24'd0, v}, 32'd0);
        tick();
        read_v(0, v);
        check("t_v0_e1", {24'd0, v}, 32'd60);
        tick();
        tick();
        check("t_done_e3", {31'd0, sweep_done}, 32'd0);
        tick();
        check("t_done_e4", {31'd0, sweep_done}, 32'd1);
        check("t_busy_e4", {31'd0, busy}, 32'd1);
        check("t_spike_e4", {28'd0, spike_out}, 32'd0);
        tick();
        check("t_done_e5", {31'd0, sweep_done}, 32'd0);
        check("t_busy_e5", {31'd0, busy}, 32'd0);
        count_done(12, cnt);
        check("t_single_sweep", cnt, 0);

        // Cadence with en held high
        current_in = 32'h0;
        en = 1'b1;
        wait_done();
        last  = 0;
        ndone = 0;
        nlow  = 0;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (busy === 1'b0) nlow++;
            if (sweep_done === 1'b1) begin
                check($sformatf("cad_gap%0d", ndone), c - last, 6);
                last = c;
                ndone++;
            end
        end
        check("cad_pulses", ndone, 3);
        check("cad_busy_low", nlow, 3);
        en = 1'b0;
        wait_idle();

        // Snapshot: current changed mid-sweep is ignored
        do_reset();
        current_in = 32'h64000000;
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        current_in = 32'hFF000000;
        wait_done();
        check("snap_spike", {28'd0, spike_out}, 32'd0);
        read_v(3, v);
        check("snap_v3", {24'd0, v}, 32'd100);

        // Reset mid-sweep
        do_reset();
        run_sweep(32'h000064FF);
        check("mid_pre_spike", {28'd0, spike_out}, 32'd1);
        read_v(1, v);
        check("mid_pre_v1", {24'd0, v}, 32'd100);
        wait_idle();
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_spike", {28'd0, spike_out}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_done", {31'd0, sweep_done}, 32'd0);
        check_all_v("mid", 32'h0);
        count_done(10, cnt);
        check("mid_no_done", cnt, 0);
        run_sweep(32'h0000003C);
        check("post_spike", {28'd0, spike_out}, 32'd0);
        check_all_v("post", 32'h0000003C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
